io_device_bank: RTL and testbench

- Peripheral-side responder for the CPU memory-mapped IO decode.
- Consumes the chip-select strobes and write data produced by the CPU-side address decoder, and holds the LED and seven-segment registers.
- Synchronises the switches and debounces the confirm button; returns switch data and a sticky confirm flag to the decoder's read mux.
- Drives the board LED, 8-digit seven-segment and anode pins.

---
 rtl/io_pkg.sv | 37 +++
 rtl/hex_to_seg7.sv | 36 +++
 rtl/io_device_bank.sv | 179 +++++++++++++++++
 tb/tb_io_device_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: constants shared between the CPU-side IO decoder and the
// peripheral-side device bank.
//   - IO register addresses decoded by the CPU side
//   - active-low seven-segment glyphs {dp,g,f,e,d,c,b,a} for hex 0-F
//   - default timing for button debounce and display scanning (100 MHz clock)
package io_pkg;

  // Memory-mapped IO addresses (word aligned), decoded on the CPU side
  localparam logic [31:0] IO_LED_ADDR    = 32'hFFFF_FC60;
  localparam logic [31:0] IO_SWITCH_ADDR = 32'hFFFF_FC70;
  localparam logic [31:0] IO_BTN_ADDR    = 32'hFFFF_FC74;
  localparam logic [31:0] IO_SEG_ADDR    = 32'hFFFF_FC80;

  // Active-low glyphs; bit 7 (dp) is always 1 so the decimal point stays dark
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // 10 ms debounce and 1 ms per digit at 100 MHz
  localparam logic [19:0] DEBOUNCE_CYCLES_DEF = 20'd1000000;
  localparam logic [16:0] SCAN_CYCLES_DEF     = 17'd100000;

endpackage : io_pkg

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment glyph.
// Ports:
//   nibble  in  4  hex digit value 0-F
//   seg     out 8  glyph {dp,g,f,e,d,c,b,a}, active-low, dp off
module hex_to_seg7
  import io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Glyph lookup; unknown selects fall back to a blank digit
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : hex_to_seg7

// File: rtl/io_device_bank.sv
// io_device_bank: peripheral-side responder for the CPU memory-mapped IO.
// Holds the LED and seven-segment registers written through decoder strobes,
// synchronises the switches, debounces the confirm button into a sticky flag,
// and time-multiplexes the 8-digit seven-segment display.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   led_ctrl      LED register write strobe
//   seg_ctrl      seven-segment register write strobe
//   btn_ctrl      confirm-flag read strobe (read consumes the flag)
//   write_data    32-bit store data
//   switch_in     raw switches (async)
//   btn_in        raw confirm button (async, active-high)
//   switch_data   synchronised switches to decoder read mux
//   conf_btn_out  sticky confirm flag to decoder read mux
//   led_out       board LEDs
//   seg_an        digit anodes, active-low one-hot
//   seg_out       segments {dp,g,f,e,d,c,b,a}, active-low
module io_device_bank
  import io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [16:0] SCAN_CYCLES     = SCAN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_ctrl,
  input  logic        seg_ctrl,
  input  logic        btn_ctrl,
  input  logic [31:0] write_data,
  input  logic [7:0]  switch_in,
  input  logic        btn_in,
  output logic [7:0]  switch_data,
  output logic        conf_btn_out,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  logic [15:0] led_q, led_d;
  logic [31:0] seg_reg_q, seg_reg_d;
  logic [7:0]  sw_sync1_q, sw_sync1_d;
  logic [7:0]  sw_sync2_q, sw_sync2_d;
  logic [7:0]  sw_data_q, sw_data_d;
  logic        btn_sync1_q, btn_sync1_d;
  logic        btn_sync2_q, btn_sync2_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        btn_db_q, btn_db_d;
  logic        btn_db_prev_q, btn_db_prev_d;
  logic        conf_q, conf_d;
  logic [16:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  digit_idx_q, digit_idx_d;
  logic [7:0]  seg_an_q, seg_an_d;
  logic [7:0]  seg_out_q, seg_out_d;
  logic        btn_rise_s;
  logic [3:0]  nibble_s;
  logic [7:0]  glyph_s;

  // CPU-written registers and input synchronisers
  always_comb begin
    led_d = led_q;
    if (led_ctrl) begin
      led_d = write_data[15:0];
    end else begin
      led_d = led_q;
    end

    seg_reg_d = seg_reg_q;
    if (seg_ctrl) begin
      seg_reg_d = write_data;
    end else begin
      seg_reg_d = seg_reg_q;
    end

    sw_sync1_d  = switch_in;
    sw_sync2_d  = sw_sync1_q;
    sw_data_d   = sw_sync2_q;
    btn_sync1_d = btn_in;
    btn_sync2_d = btn_sync1_q;
  end

  // Button debounce: a new level must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_sync2_q != btn_db_q) begin
      if (db_cnt_q == (DEBOUNCE_CYCLES - 20'd1)) begin
        btn_db_d = btn_sync2_q;
        db_cnt_d = 20'd0;
      end else begin
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q + 20'd1;
      end
    end else begin
      // levels agree again: any partial count was a glitch
      db_cnt_d = 20'd0;
    end
    btn_db_prev_d = btn_db_q;
  end

  // Sticky confirm flag: a press sets it, a read clears it, a press beats a read
  always_comb begin
    btn_rise_s = btn_db_q & ~btn_db_prev_q;
    conf_d     = conf_q;
    if (btn_rise_s) begin
      conf_d = 1'b1;
    end else if (btn_ctrl) begin
      conf_d = 1'b0;
    end else begin
      conf_d = conf_q;
    end
  end

  // Display scan: advance one digit per SCAN_CYCLES; anode and glyph come from
  // the next-state index and register so both outputs always describe the same
  // digit and switch on the same edge.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == (SCAN_CYCLES - 17'd1)) begin
      scan_cnt_d  = 17'd0;
      digit_idx_d = digit_idx_q + 3'd1;
    end else begin
      scan_cnt_d  = scan_cnt_q + 17'd1;
      digit_idx_d = digit_idx_q;
    end
    nibble_s  = seg_reg_d[{digit_idx_d, 2'b00} +: 4];
    seg_an_d  = ~(8'b0000_0001 << digit_idx_d);
    seg_out_d = glyph_s;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_s),
    .seg    (glyph_s)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q         <= 16'h0000;
      seg_reg_q     <= 32'h0000_0000;
      sw_sync1_q    <= 8'h00;
      sw_sync2_q    <= 8'h00;
      sw_data_q     <= 8'h00;
      btn_sync1_q   <= 1'b0;
      btn_sync2_q   <= 1'b0;
      db_cnt_q      <= 20'd0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      conf_q        <= 1'b0;
      scan_cnt_q    <= 17'd0;
      digit_idx_q   <= 3'd0;
      seg_an_q      <= 8'hFE;
      seg_out_q     <= SEG_0;
    end else begin
      led_q         <= led_d;
      seg_reg_q     <= seg_reg_d;
      sw_sync1_q    <= sw_sync1_d;
      sw_sync2_q    <= sw_sync2_d;
      sw_data_q     <= sw_data_d;
      btn_sync1_q   <= btn_sync1_d;
      btn_sync2_q   <= btn_sync2_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      conf_q        <= conf_d;
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      seg_an_q      <= seg_an_d;
      seg_out_q     <= seg_out_d;
    end
  end

  assign led_out      = led_q;
  assign switch_data  = sw_data_q;
  assign conf_btn_out = conf_q;
  assign seg_an       = seg_an_q;
  assign seg_out      = seg_out_q;

endmodule : io_device_bank

// File: tb/tb_io_device_bank.sv
// Directed self-checking bench for io_device_bank with short timing
// (DEBOUNCE_CYCLES=4, SCAN_CYCLES=2). Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_io_device_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        led_ctrl;
  logic        seg_ctrl;
  logic        btn_ctrl;
  logic [31:0] write_data;
  logic [7:0]  switch_in;
  logic        btn_in;
  logic [7:0]  switch_data;
  logic        conf_btn_out;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  io_device_bank #(
    .DEBOUNCE_CYCLES (20'd4),
    .SCAN_CYCLES     (17'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .led_ctrl     (led_ctrl),
    .seg_ctrl     (seg_ctrl),
    .btn_ctrl     (btn_ctrl),
    .write_data   (write_data),
    .switch_in    (switch_in),
    .btn_in       (btn_in),
    .switch_data  (switch_data),
    .conf_btn_out (conf_btn_out),
    .led_out      (led_out),
    .seg_an       (seg_an),
    .seg_out      (seg_out)
  );

  always #5 clk = ~clk;

  // Expected active-low glyph for a hex digit
  function automatic logic [7:0] exp_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  4'hF: return 8'h8E;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; led_ctrl = 1'b0; seg_ctrl = 1'b0; btn_ctrl = 1'b0;
    write_data = 32'h0; switch_in = 8'h00; btn_in = 1'b0;
    step(2);
    rst = 1'b0;
    total_cnt++;
    if (led_out !== 16'h0000) $display("FAIL reset_led: got %h expected 0000", led_out);
    else pass_cnt++;
    total_cnt++;
    if (switch_data !== 8'h00) $display("FAIL reset_sw: got %h expected 00", switch_data);
    else pass_cnt++;
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL reset_flag: got %b expected 0", conf_btn_out);
    else pass_cnt++;
    total_cnt++;
    if (seg_an !== 8'hFE) $display("FAIL reset_an: got %h expected FE", seg_an);
    else pass_cnt++;
    total_cnt++;
    if (seg_out !== 8'hC0) $display("FAIL reset_seg: got %h expected C0", seg_out);
    else pass_cnt++;
  endtask

  task automatic test_led;
    write_data = 32'hABCD_1234; led_ctrl = 1'b1;
    step(1);
    led_ctrl = 1'b0;
    total_cnt++;
    if (led_out !== 16'h1234) $display("FAIL led_write: got %h expected 1234", led_out);
    else pass_cnt++;
    write_data = 32'hFFFF_FFFF;
    step(3);
    total_cnt++;
    if (led_out !== 16'h1234) $display("FAIL led_hold: got %h expected 1234", led_out);
    else pass_cnt++;
  endtask

  task automatic test_switch;
    switch_in = 8'h5A;
    step(1);
    total_cnt++;
    if (switch_data !== 8'h00) $display("FAIL sw_edge1: got %h expected 00", switch_data);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (switch_data !== 8'h00) $display("FAIL sw_edge2: got %h expected 00", switch_data);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (switch_data !== 8'h5A) $display("FAIL sw_edge3: got %h expected 5A", switch_data);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | conf_btn_out;
    end
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | conf_btn_out;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL glitch_reject: got flag %b expected 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_debounce;
    btn_in = 1'b1;
    step(6);
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL deb_early: got %b expected 0 after 6 edges", conf_btn_out);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (conf_btn_out !== 1'b1) $display("FAIL deb_set: got %b expected 1 after 7 edges", conf_btn_out);
    else pass_cnt++;
    step(5);
    total_cnt++;
    if (conf_btn_out !== 1'b1) $display("FAIL deb_sticky: got %b expected 1", conf_btn_out);
    else pass_cnt++;
  endtask

  task automatic test_clear;
    btn_ctrl = 1'b1;
    step(1);
    btn_ctrl = 1'b0;
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL flag_clear: got %b expected 0", conf_btn_out);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL flag_no_reset: got %b expected 0 while held", conf_btn_out);
    else pass_cnt++;
    // a debounced release must not raise the flag
    btn_in = 1'b0;
    step(12);
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL release_noflag: got %b expected 0", conf_btn_out);
    else pass_cnt++;
  endtask

  task automatic test_coincident;
    btn_in = 1'b1;
    step(5);
    btn_ctrl = 1'b1;
    step(1);
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL coinc_pre: got %b expected 0", conf_btn_out);
    else pass_cnt++;
    step(1);
    btn_ctrl = 1'b0;
    total_cnt++;
    if (conf_btn_out !== 1'b1) $display("FAIL coinc_set_wins: got %b expected 1", conf_btn_out);
    else pass_cnt++;
  endtask

  task automatic test_seg_scan;
    logic [31:0] data;
    logic [2:0]  idx;
    logic [7:0]  e_an;
    logic [7:0]  e_seg;
    int          errs;
    data = 32'h0123_ABCD;
    errs = 0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    seg_ctrl = 1'b1;
    write_data = data;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      seg_ctrl = 1'b0;
      idx   = 3'((k / 2) % 8);
      e_an  = ~(8'h01 << idx);
      e_seg = exp_glyph(data[idx*4 +: 4]);
      total_cnt++;
      if (seg_an !== e_an) $display("FAIL scan_an[%0d]: got %h expected %h", k, seg_an, e_an);
      else pass_cnt++;
      total_cnt++;
      if (seg_out !== e_seg) $display("FAIL scan_seg[%0d]: got %h expected %h", k, seg_out, e_seg);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_debounce;
    btn_in = 1'b0;
    step(10);
    btn_in = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL rstmid_flag: got %b expected 0", conf_btn_out);
    else pass_cnt++;
    step(6);
    total_cnt++;
    if (conf_btn_out !== 1'b0) $display("FAIL rstmid_early: got %b expected 0 after 6 edges", conf_btn_out);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (conf_btn_out !== 1'b1) $display("FAIL rstmid_set: got %b expected 1 after 7 edges", conf_btn_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_led();
    test_switch();
    test_glitch();
    test_debounce();
    test_clear();
    test_coincident();
    test_seg_scan();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_io_device_bank
